// File: rtl/ft_tx_mux_pkg.sv
// Shared types and constants for the FT60x write-side multiplexer.
package ft_tx_mux_pkg;

  // Write-path sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StGap
  } tx_state_e;

  // Header magic values that open every burst.
  localparam logic [7:0] HdrMagic32 = 8'hA5;
  localparam logic [3:0] HdrMagic16 = 4'hA;

  // FT60x bus widths.
  localparam int unsigned Ft600DataW = 16;
  localparam int unsigned Ft601DataW = 32;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index width that stays at least one bit wide for a single channel.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ft_tx_mux_rr_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping.
module ft_tx_mux_rr_arbiter
  import ft_tx_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            en_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [IdxW-1:0] hi_idx, lo_idx;
  logic            hi_vld, lo_vld;

  // Lowest requester above ptr wins; otherwise lowest at or below ptr (wrap-around).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        if (32'(k) > 32'(ptr_i)) begin
          hi_vld = 1'b1;
          hi_idx = IdxW'(k);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IdxW'(k);
        end
      end
    end
    gnt_idx_o = hi_vld ? hi_idx : lo_idx;
    gnt_vld_o = en_i && (hi_vld || lo_vld);
  end

endmodule

// File: rtl/ft_tx_mux.sv
// FT60x 245-sync FIFO write master: round-robin bursts from CH_N streams,
// optional header word per burst, TXE_N back-pressure on a one-word output register.
module ft_tx_mux
  import ft_tx_mux_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CH_N      = 4,
  parameter int unsigned BURST_LEN = 256,
  parameter bit          HDR_EN    = 1'b1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [CH_N*DATA_W-1:0]     ch_data_in,
  input  logic [CH_N*(DATA_W/8)-1:0] ch_be_in,
  input  logic [CH_N-1:0]            ch_valid_in,
  output logic [CH_N-1:0]            ch_ready_out,
  input  logic                       txe_n_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [DATA_W/8-1:0]        be_out,
  output logic                       data_oe_out,
  output logic                       wr_n_out,
  output logic                       busy_out,
  output logic [2:0]                 grant_out
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned IdxW = idx_w(CH_N);
  localparam int unsigned CntW = clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_LEN);

  tx_state_e         state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic [15:0]       seq_q, seq_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovalid_q, ovalid_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [BE_W-1:0]   obe_q, obe_d;

  logic [IdxW-1:0]   arb_idx;
  logic              arb_vld;
  logic [DATA_W-1:0] sel_data, hdr_word;
  logic [BE_W-1:0]   sel_be;
  logic              sel_valid, xfer, ready_g, load;

  ft_tx_mux_rr_arbiter #(
    .N    (CH_N),
    .IdxW (IdxW)
  ) u_arb (
    .req_i     (ch_valid_in),
    .ptr_i     (ptr_q),
    .en_i      ((state_q == StIdle) && !txe_n_in),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Pick the granted channel's word, byte enables and valid.
  always_comb begin
    sel_data  = '0;
    sel_be    = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < int'(CH_N); k++) begin
      if (gnt_q == IdxW'(k)) begin
        sel_data  = ch_data_in[k*DATA_W +: DATA_W];
        sel_be    = ch_be_in[k*BE_W +: BE_W];
        sel_valid = ch_valid_in[k];
      end
    end
  end

  // Header for the channel being granted right now, stamped with the burst sequence.
  always_comb begin
    if (DATA_W == 32) hdr_word = DATA_W'({HdrMagic32, 8'(arb_idx), seq_q});
    else              hdr_word = DATA_W'({HdrMagic16, 4'(arb_idx), seq_q[7:0]});
  end

  assign xfer = ovalid_q && !txe_n_in;
  assign load = ready_g && sel_valid;

  // Next-state, output-register and handshake logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    obe_d    = obe_q;
    ready_g  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          gnt_d = arb_idx;
          ptr_d = arb_idx;
          cnt_d = '0;
          if (HDR_EN) begin
            state_d  = StHdr;
            ovalid_d = 1'b1;
            odata_d  = hdr_word;
            obe_d    = '1;
          end else begin
            state_d = StData;
          end
        end
      end
      StHdr: begin
        // Data may refill the register on the same edge the header leaves.
        ready_g = (cnt_q < BurstMax) && xfer;
        if (xfer) begin
          seq_d    = seq_q + 16'd1;
          ovalid_d = 1'b0;
          state_d  = StData;
        end
      end
      StData: begin
        ready_g = (cnt_q < BurstMax) && (!ovalid_q || xfer);
        if (xfer) ovalid_d = 1'b0;
        // A producer bubble ends the burst early.
        if (!ovalid_q && ((cnt_q == BurstMax) || !sel_valid)) state_d = StGap;
      end
      StGap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = sel_data;
      obe_d    = sel_be;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  // State and output register; pointer resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      ptr_q    <= IdxW'(CH_N - 1);
      gnt_q    <= '0;
      seq_q    <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      obe_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      obe_q    <= obe_d;
    end
  end

  // Only the granted channel ever sees ready.
  always_comb begin
    ch_ready_out = '0;
    for (int k = 0; k < int'(CH_N); k++) begin
      ch_ready_out[k] = ready_g && (gnt_q == IdxW'(k));
    end
  end

  assign wr_n_out    = !ovalid_q;
  assign data_oe_out = ovalid_q;
  assign data_out    = odata_q;
  assign be_out      = obe_q;
  assign busy_out    = (state_q != StIdle);
  assign grant_out   = 3'(gnt_q);

endmodule

// File: tb/tb_ft_tx_mux.sv
// Scoreboard bench for ft_tx_mux: queue-fed producers, expected bus words queued
// at stimulus time, independent monitors pop and compare on every bus transfer.
module tb_ft_tx_mux;

  localparam int unsigned CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic txe_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 4-channel, burst 4, header on
  logic [CH*32-1:0] a_data_in;
  logic [CH*4-1:0]  a_be_in;
  logic [CH-1:0]    a_valid, a_ready;
  logic [31:0]      a_data;
  logic [3:0]       a_be;
  logic             a_oe, a_wr_n, a_busy;
  logic [2:0]       a_grant;

  // 16-bit, 2-channel, burst 2, no header
  logic [31:0] c_data_in;
  logic [3:0]  c_be_in;
  logic [1:0]  c_valid, c_ready;
  logic [15:0] c_data;
  logic [1:0]  c_be;
  logic        c_oe, c_wr_n, c_busy;
  logic [2:0]  c_grant;

  ft_tx_mux #(.DATA_W(32), .CH_N(CH), .BURST_LEN(4), .HDR_EN(1'b1)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .ch_data_in(a_data_in), .ch_be_in(a_be_in),
    .ch_valid_in(a_valid), .ch_ready_out(a_ready), .txe_n_in(txe_n), .data_out(a_data),
    .be_out(a_be), .data_oe_out(a_oe), .wr_n_out(a_wr_n), .busy_out(a_busy),
    .grant_out(a_grant)
  );

  ft_tx_mux #(.DATA_W(16), .CH_N(2), .BURST_LEN(2), .HDR_EN(1'b0)) dut_c (
    .clk_in(clk), .rst_in(rst_n), .ch_data_in(c_data_in), .ch_be_in(c_be_in),
    .ch_valid_in(c_valid), .ch_ready_out(c_ready), .txe_n_in(txe_n), .data_out(c_data),
    .be_out(c_be), .data_oe_out(c_oe), .wr_n_out(c_wr_n), .busy_out(c_busy),
    .grant_out(c_grant)
  );

  int checks = 0;
  int errors = 0;
  logic [35:0] src_q [CH][$];
  logic [35:0] exp_q [$];
  logic [17:0] c_exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int ch, input logic [31:0] w);
    src_q[ch].push_back({4'hF, w});
  endtask

  task automatic expect_a(input logic [31:0] w);
    exp_q.push_back({4'hF, w});
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || a_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()) + 64'(a_busy), 64'd0);
  endtask

  task automatic wait_a_word(input logic [31:0] w);
    int n;
    n = 0;
    while (!(a_data == w && !a_wr_n) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Producer for dut_a: present queue head, pop when the DUT consumed it.
  initial begin
    logic [CH-1:0] take;
    a_valid   = '0;
    a_data_in = '0;
    a_be_in   = '0;
    forever begin
      @(negedge clk);
      take = a_valid & a_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(CH); k++) begin
        if (take[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        a_valid[k] = (src_q[k].size() > 0);
        if (src_q[k].size() > 0) begin
          a_data_in[k*32 +: 32] = src_q[k][0][31:0];
          a_be_in[k*4 +: 4]     = src_q[k][0][35:32];
        end
      end
    end
  end

  // Monitor for dut_a: every word about to transfer must match the next expectation.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !a_wr_n && !txe_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_bus: got unexpected word %0h expected none", a_data);
        end else begin
          e = exp_q.pop_front();
          check("a_bus", {27'd0, a_oe, a_be, a_data}, {27'd0, 1'b1, e});
        end
      end
    end
  end

  // Monitor for dut_c.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !c_wr_n && !txe_n) begin
        if (c_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL c_bus: got unexpected word %0h expected none", c_data);
        end else begin
          e = c_exp_q.pop_front();
          check("c_bus", {45'd0, c_oe, c_be, c_data}, {45'd0, 1'b1, e});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ch;
    logic [15:0] c_words [3];
    logic [1:0]  c_bes [3];
    int          c_chs [3];
    c_valid   = '0;
    c_data_in = '0;
    c_be_in   = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_n", 64'(a_wr_n), 64'd1);
    check("rst_oe", 64'(a_oe), 64'd0);
    check("rst_data", 64'(a_data), 64'd0);
    check("rst_be", 64'(a_be), 64'd0);
    check("rst_ready", 64'(a_ready), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_grant", 64'(a_grant), 64'd0);
    check("rst_c_wr_n", 64'(c_wr_n), 64'd1);
    rst_n = 1'b1;

    // Single-channel burst of 4, then the next header carries seq 1.
    expect_a(32'hA500_0000);
    for (int i = 0; i < 4; i++) begin
      send(0, 32'h1000 + 32'(i));
      expect_a(32'h1000 + 32'(i));
    end
    drain_a("t1_drain");
    send(0, 32'h2000);
    expect_a(32'hA500_0001);
    expect_a(32'h2000);
    drain_a("t1b_drain");
    check("t1_grant", 64'(a_grant), 64'd0);

    // ch1 and ch3 always valid: grants alternate 1,3,1,3.
    for (int b = 0; b < 4; b++) begin
      ch = (b % 2 == 0) ? 1 : 3;
      expect_a({8'hA5, 8'(ch), 16'(2 + b)});
      for (int i = 0; i < 4; i++)
        expect_a(((ch == 1) ? 32'h1100 : 32'h3300) + 32'((b / 2) * 4 + i));
    end
    for (int i = 0; i < 8; i++) begin
      send(1, 32'h1100 + 32'(i));
      send(3, 32'h3300 + 32'(i));
    end
    drain_a("t2_drain");
    check("t2_grant", 64'(a_grant), 64'd3);

    // TXE_N stall with 0x1002 on the bus.
    expect_a(32'hA500_0006);
    for (int i = 0; i < 4; i++) begin
      send(0, 32'h1000 + 32'(i));
      expect_a(32'h1000 + 32'(i));
    end
    wait_a_word(32'h1001);
    check("t3_reach", 64'(a_data), 64'h1001);
    @(posedge clk);
    #1 txe_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_hold_data", 64'(a_data), 64'h1002);
      check("t3_hold_wr_n", 64'(a_wr_n), 64'd0);
      check("t3_hold_ready", 64'(a_ready), 64'd0);
      @(posedge clk);
    end
    #1 txe_n = 1'b0;
    drain_a("t3_drain");

    // ch2 runs dry after 2 words; ch1 takes the next grant.
    send(2, 32'h2200);
    send(2, 32'h2201);
    expect_a(32'hA502_0007);
    expect_a(32'h2200);
    expect_a(32'h2201);
    n = 0;
    while (!(a_busy && a_grant == 3'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_grant2", 64'(a_grant), 64'd2);
    send(1, 32'h1108);
    expect_a(32'hA501_0008);
    expect_a(32'h1108);
    n = 0;
    while (!(a_busy && a_grant == 3'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_grant1", 64'(a_grant), 64'd1);
    drain_a("t4_drain");

    // Asynchronous reset mid-burst on ch3.
    expect_a(32'hA503_0009);
    expect_a(32'h5000);
    for (int i = 0; i < 4; i++) send(3, 32'h5000 + 32'(i));
    wait_a_word(32'h5000);
    check("t5_reach", 64'(a_data), 64'h5000);
    #2 rst_n = 1'b0;
    #1;
    check("t5_wr_n", 64'(a_wr_n), 64'd1);
    check("t5_oe", 64'(a_oe), 64'd0);
    check("t5_busy", 64'(a_busy), 64'd0);
    check("t5_grant", 64'(a_grant), 64'd0);
    check("t5_exp_left", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < int'(CH); k++) src_q[k].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_a(32'hA500_0000);
    expect_a(32'h6000);
    expect_a(32'hA502_0001);
    expect_a(32'h6200);
    send(0, 32'h6000);
    send(2, 32'h6200);
    drain_a("t5_drain");

    // 16-bit, no header: raw words with their byte enables.
    c_words[0] = 16'hBEEF; c_bes[0] = 2'b01; c_chs[0] = 0;
    c_words[1] = 16'h1234; c_bes[1] = 2'b10; c_chs[1] = 1;
    c_words[2] = 16'h00A5; c_bes[2] = 2'b11; c_chs[2] = 0;
    for (int v = 0; v < 3; v++) begin
      c_exp_q.push_back({c_bes[v], c_words[v]});
      @(posedge clk);
      #1;
      c_data_in[c_chs[v]*16 +: 16] = c_words[v];
      c_be_in[c_chs[v]*2 +: 2]     = c_bes[v];
      c_valid[c_chs[v]]            = 1'b1;
      n = 0;
      while (!c_ready[c_chs[v]] && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_ready", 64'(c_ready[c_chs[v]]), 64'd1);
      @(posedge clk);
      #1 c_valid = '0;
      n = 0;
      while ((c_exp_q.size() != 0 || c_busy) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_drain", 64'(c_exp_q.size()) + 64'(c_busy), 64'd0);
      check("t6_grant", 64'(c_grant), 64'(c_chs[v]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft_tx_mux.md
Name: ft_tx_mux

Overview:
Parametrised write-side master for the FT60x 245-synchronous FIFO bus. It runs in the FTDI clock domain. It takes CH_N independent producer streams, already crossed into this domain by per-channel gateways. It arbitrates between them round-robin in bursts, optionally prefixes each burst with a header word, and drives DATA/BE/WR_N with correct TXE_N back-pressure. It replaces the single-stream gateway write path. The top level keeps only the inout tristate: the bus is driven when data_oe_out is high.

Parameters:
DATA_W, 32, bus width; 16 (FT600) or 32 (FT601)
BE_W, DATA_W/8, byte-enable width (derived, not overridden)
CH_N, 4, number of input channels, 1..8
BURST_LEN, 256, maximum data words per grant, 1..65535
HDR_EN, 1, 1 = emit one header word before each burst's data

Ports:
clk_in  in  1  FTDI clock, 100 MHz
rst_in  in  1  asynchronous active-low reset
ch_data_in  in  CH_N*DATA_W  channel words; channel k occupies [k*DATA_W +: DATA_W]
ch_be_in  in  CH_N*BE_W  byte enables travelling with each word
ch_valid_in  in  CH_N  word available on channel k
ch_ready_out  out  CH_N  word on channel k consumed at this edge (valid & ready)
txe_n_in  in  1  FT60x TX FIFO not-full, active low
data_out  out  DATA_W  bus data
be_out  out  BE_W  bus byte enables
data_oe_out  out  1  drive enable for DATA/BE
wr_n_out  out  1  write strobe, active low
busy_out  out  1  high when not IDLE
grant_out  out  3  currently or last granted channel index

Behaviour:
- Reset values (applied immediately, asynchronously): wr_n_out=1, data_oe_out=0, data_out=0, be_out=0, ch_ready_out=0, busy_out=0, grant_out=0. Output register empty. Burst sequence counter = 0. Round-robin pointer = CH_N-1, so channel 0 wins first.
- Transfer rule: a word leaves the output register on an edge where wr_n_out==0 && txe_n_in==0 ("xfer"). Whenever the output register holds a word, wr_n_out=0 and data_oe_out=1. If txe_n_in is high, the word is held stable; it is never dropped or duplicated.
- FSM states: IDLE, HDR, DATA, GAP.
- IDLE: take a grant when txe_n_in==0 and |ch_valid_in.
  - Grant goes to the first valid channel searching cyclically from pointer+1.
  - Register the grant, pointer and grant_out.
  - Next state is HDR if HDR_EN, else DATA.
- HDR: output register is loaded with the header and be_out is all ones.
  - 32-bit header: {8'hA5, 8'(ch), 16'(seq)}.
  - 16-bit header: {4'hA, 4'(ch), 8'(seq[7:0])}.
  - On xfer: seq increments (wraps at 2^16) and the state moves to DATA.
  - Data may be loaded on that same edge (see ready rule).
- DATA: data_out and be_out come from the granted channel's word and BE.
  - ready[g] = cnt<BURST_LEN && (HDR ? xfer : (!ovalid || xfer)). All other ready bits are 0.
  - Load happens on ready[g] && valid[g]; cnt increments per load.
  - This gives back-to-back words: one word per cycle while txe_n_in is low.
  - Leave for GAP when ovalid==0 && (cnt==BURST_LEN || !ch_valid_in[g]). A producer bubble therefore ends the burst early.
- GAP: one cycle with wr_n_out=1 and data_oe_out=0, then IDLE.
- Latency: valid seen in IDLE gives the header on the bus the next cycle. First data follows one cycle after header xfer.
- An empty burst (HDR_EN=1, channel valid drops before the first load) emits the header followed by zero data words. This is legal.
- CH_N=1: the arbiter degenerates to a constant grant.
- Reset mid-burst: the word in flight is lost; the seq counter restarts at 0.

Decomposition:
- Shared package/header ft_pkg: state encoding, header magic constants (8'hA5, 4'hA), clog2 function, FT60x width constants.
- Sub-module rr_arbiter: parameter N.
  - Inputs: req[N], ptr, en.
  - Outputs: gnt_idx, gnt_vld.
  - Purely combinational search.
  - The pointer register stays in ft_tx_mux.

Test Plan:
1. CH_N=4, DATA_W=32, BURST_LEN=4, HDR_EN=1, txe_n low, ch0 streams 0x1000.. -> bus shows 0xA5000000, 0x1000..0x1003 on 5 consecutive xfers; GAP; the next ch0 header is 0xA5000001.
2. ch1 and ch3 continuously valid from reset -> grant order 1,3,1,3; headers 0xA5010000, 0xA5030001, ...
3. txe_n high for 3 cycles while 0x1002 is on the bus -> data_out=0x1002 and wr_n_out=0 held; ch_ready_out=0; the sink receives 0x1001, 0x1002, 0x1003 exactly once.
4. BURST_LEN=8, ch2 valid for only 2 words -> header plus 2 data words, GAP, return to IDLE; the next grant goes to another requester.
5. rst_in low mid-DATA -> wr_n_out=1 and data_oe_out=0 without waiting for an edge. After release: first header 0xA5000000 on ch0.
6. DATA_W=16, HDR_EN=0, ch0 word 0xBEEF with be 2'b01 -> data_out=0xBEEF, be_out=2'b01, no header word.
